// File: rtl/untrusted_ram_ctrl_if.sv
// Request/response bus between the core data arbiter and untrusted_ram_ctrl.
//   req_i/we_i/addr_i/mask_i/wdata_i : one request per cycle, no grant
//   parity_flip_i                    : XORed into stored parity on writes (tie 0 in product)
//   rvalid_o/rdata_o/err_o           : registered read response, one cycle after request
//   init_done_o                      : storage zero-initialisation complete
interface untrusted_ram_ctrl_if #(
  parameter int unsigned AddrWidth = 15
);
  logic                 req_i;
  logic                 we_i;
  logic [AddrWidth-1:0] addr_i;
  logic [31:0]          mask_i;
  logic [31:0]          wdata_i;
  logic [3:0]           parity_flip_i;
  logic                 rvalid_o;
  logic [31:0]          rdata_o;
  logic                 err_o;
  logic                 init_done_o;

  modport master (
    output req_i, we_i, addr_i, mask_i, wdata_i, parity_flip_i,
    input  rvalid_o, rdata_o, err_o, init_done_o
  );

  modport slave (
    input  req_i, we_i, addr_i, mask_i, wdata_i, parity_flip_i,
    output rvalid_o, rdata_o, err_o, init_done_o
  );
endinterface

// File: rtl/untrusted_ram_ctrl.sv
// Single-port word-addressed RAM controller for the untrusted device.
// Accepts one request per cycle, applies bit-masked writes, returns exactly one
// registered response per read one cycle later, and zero-initialises storage
// (one word per cycle) after reset. Writes never produce a response.
//
// Optional feature: define UNTRUSTED_RAM_PARITY_EN to add one even-parity bit per
// byte lane; a read with any lane mismatch returns err_o=1, rdata_o=0.
//
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : untrusted_ram_ctrl_if slave modport (request, response, init_done_o)
module untrusted_ram_ctrl #(
  parameter int unsigned Depth     = 32768,
  parameter int unsigned AddrWidth = 15
) (
  input logic                  clk_i,
  input logic                  rst_i,
  untrusted_ram_ctrl_if.slave  bus
);

  localparam int unsigned         IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth:0]  DepthW = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth:0]  LastW  = (AddrWidth+1)'(Depth - 1);

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  state_e               state_q, state_d;
  // One bit wider than the address so Depth = 2^AddrWidth terminates without wrap.
  logic [AddrWidth:0]   cnt_q, cnt_d;

  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [31:0]          mem [Depth];
  logic [IdxW-1:0]      idx;
  logic [IdxW-1:0]      init_idx;
  logic                 in_range;
  logic [31:0]          rd_word;
  logic [31:0]          wr_word;
  logic                 init_we;
  logic                 wr_en;
  logic                 par_err;

  assign idx      = bus.addr_i[IdxW-1:0];
  assign init_idx = cnt_q[IdxW-1:0];
  assign in_range = ({1'b0, bus.addr_i} < DepthW);
  assign rd_word  = mem[idx];
  assign wr_word  = (rd_word & ~bus.mask_i) | (bus.wdata_i & bus.mask_i);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    init_we  = 1'b0;
    wr_en    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + (AddrWidth+1)'(1);
        if (cnt_q == LastW) begin
          state_d = READY;
        end
        // Reads during INIT still get a response so the arbiter stays in sync;
        // writes are dropped.
        if (bus.req_i && !bus.we_i) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end
      end
      READY: begin
        if (bus.req_i) begin
          if (bus.we_i) begin
            wr_en = in_range;
          end else begin
            rvalid_d = 1'b1;
            if (!in_range || par_err) begin
              err_d = 1'b1;
            end else begin
              rdata_d = rd_word;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage has no reset: INIT rewrites every word after each reset.
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      mem[init_idx] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wr_word;
    end
  end

`ifdef UNTRUSTED_RAM_PARITY_EN
  logic [3:0] par_mem [Depth];
  logic [3:0] par_old;
  logic [3:0] par_new;

  assign par_old = par_mem[idx];

  // Lanes with an all-zero mask keep their old parity bit.
  always_comb begin
    par_new = par_old;
    par_err = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (|bus.mask_i[8*i +: 8]) begin
        par_new[i] = (^wr_word[8*i +: 8]) ^ bus.parity_flip_i[i];
      end
      if ((^rd_word[8*i +: 8]) != par_old[i]) begin
        par_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_we) begin
      par_mem[init_idx] <= '0;
    end else if (wr_en) begin
      par_mem[idx] <= par_new;
    end
  end
`else
  logic unused_flip;
  assign unused_flip = ^bus.parity_flip_i;
  assign par_err     = 1'b0;
`endif

  assign bus.rvalid_o    = rvalid_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.init_done_o = (state_q == READY);

endmodule

// File: doc/untrusted_ram_ctrl.md
# untrusted_ram_ctrl

Single-port word-addressed RAM controller for the untrusted device, sitting directly downstream of the core data arbiter's RAM interface. It accepts one request per cycle with no backpressure and applies bit-masked writes. Every read returns exactly one in-order response after a fixed one-cycle latency. It zero-initialises its storage after reset and, optionally, protects each byte lane with a parity bit whose mismatch is reported as a bus error.

## Interface
- `Depth`, 32768: number of 32-bit words; legal range 1..32768.
- `AddrWidth`, 15: word-address width; must satisfy 2^AddrWidth >= Depth.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  request valid; always accepted, no grant.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  AddrWidth  word address (byte address bits [16:2]).
- `mask_i`  in  32  per-bit write mask; 1 = bit written.
- `wdata_i`  in  32  write data.
- `parity_flip_i`  in  4  DV hook: XORed into the stored parity bits on writes; tie to 0 in the product.
- `rvalid_o`  out  1  read response valid; never asserted for writes.
- `rdata_o`  out  32  read data; 0 whenever `err_o` is 1.
- `err_o`  out  1  response error.
- `init_done_o`  out  1  storage initialisation complete.

## Operation
- FSM with two states.
  - INIT: entered on reset. A counter walks 0..Depth-1 and writes data 0 and parity 0 to one word per cycle. It moves to READY after writing Depth-1.
  - READY: terminal state until the next reset.
- `init_done_o` is 1 only in READY.
- Storage is a flop array: Depth x 32 data bits, plus Depth x 4 parity bits when parity is enabled.
- Reads in READY with `addr_i` < Depth:
  - `rdata_o` is the stored word.
  - `err_o` is 1 if any lane fails parity (see Configuration). In that case `rdata_o` is 0.
- Writes in READY with `addr_i` < Depth:
  - New word = (old & ~mask_i) | (wdata_i & mask_i).
  - For each lane i whose 8 mask bits are not all 0, parity[i] = ^new[8i+7:8i] ^ parity_flip_i[i].
  - Parity of an untouched lane is unchanged.
- Out-of-range address (`addr_i` >= Depth):
  - Read: response with err=1, rdata=0.
  - Write: ignored, no side effect.
- Any request during INIT:
  - Read: response with err=1, rdata=0.
  - Write: dropped; storage keeps its INIT values.
- No write response is ever generated. The arbiter acknowledges writes itself, so a spurious `rvalid_o` would desynchronise it.

## Timing
- Reset values: `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `init_done_o`=0, FSM=INIT, counter=0.
- Read latency: read request sampled at edge T gives `rvalid_o`/`rdata_o`/`err_o` valid for exactly the cycle after T. Outputs are registered.
- Throughput is one request per cycle; back-to-back reads give back-to-back responses.
- Write at T commits at edge T. A read of the same address at T+1 returns the new data.
- `rvalid_o` is 0 in any cycle following a non-read cycle. `rdata_o` and `err_o` are 0 whenever `rvalid_o` is 0.
- INIT takes exactly Depth cycles. `init_done_o` rises in cycle Depth after reset release.
- Reset asserted mid-operation:
  - Outputs clear immediately, asynchronously.
  - A pending response is discarded.
  - INIT restarts from 0 and overwrites all contents.
- Counter width is AddrWidth+1 so that Depth=2^AddrWidth terminates without wrap.

## Configuration
- Macro `UNTRUSTED_RAM_PARITY_EN`.
- Defined:
  - Parity array is present.
  - Even parity per byte: stored bit = XOR of the lane's data bits.
  - On a read, any lane where stored parity != recomputed parity gives err=1, rdata=0.
- Undefined:
  - No parity storage or check.
  - `parity_flip_i` is ignored.
  - `err_o` is set only for out-of-range or INIT reads.

## Test plan
- Reset, Depth=16: `init_done_o`=0 for 16 cycles, then 1. Reading addr 5 gives `rvalid_o` next cycle, rdata=0x00000000, err=0.
- Read during INIT (cycle 3): rvalid=1 at cycle 4, err=1, rdata=0. A write to addr 2 during INIT leaves addr 2 reading 0 afterwards.
- Write 0xDEADBEEF with mask 0xFFFFFFFF to addr 3, then write 0x11223344 with mask 0x00FF00FF to addr 3. Read addr 3 returns 0xDE22BE44, err=0. Neither write produces `rvalid_o`.
- Back-to-back reads of addr 0, 1, 2 on consecutive cycles give three consecutive responses in order. A read of addr 16 with Depth=16 gives err=1, rdata=0.
- With `UNTRUSTED_RAM_PARITY_EN`: write 0xA5A5A5A5 (full mask) with `parity_flip_i`=4'b0100, then read. Response is err=1, rdata=0. Rewriting lane 2 only (mask 0x00FF0000, flip 0) gives err=0 on a read of 0xA5A5A5A5. Without the macro, the first read gives err=0 and data 0xA5A5A5A5.
- Assert reset while a read response is pending: `rvalid_o` drops the same cycle. After release, INIT reruns and previously written addr 3 reads 0.
